// File: rtl/mem_pkg.sv
// Shared types and constants for the memory address unit: FSM state
// encoding, abort codes, and a select range helper used by the mux and FSM.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_SEL     = 2'b11;

    // True when a (zero-extended) select value names an existing source.
    function automatic logic sel_in_range(input logic [15:0] sel, input int nsrc);
        return int'(sel) < nsrc;
    endfunction

endpackage

// File: rtl/addr_src_mux.sv
// Combinational NSRC:1 address selector over a flattened source bus.
// Source i occupies bits [i*WIDTH +: WIDTH]. A select that names no source
// produces zero rather than reaching past the end of the bus.
module addr_src_mux
    import mem_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  NSRC  = 4,
    localparam int SEL_W = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] src_addr,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      addr_out
);

    logic sel_ok;

    assign sel_ok = sel_in_range(16'(sel), NSRC);

    // Scan every source; only an exact in-range match drives the output.
    always_comb begin
        addr_out = '0;
        if (sel_ok) begin
            for (int i = 0; i < NSRC; i++) begin
                if (sel == SEL_W'(i)) begin
                    addr_out = src_addr[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory address unit: picks one of NSRC address sources, registers the
// address/store data, validates select and alignment, then runs a single
// request/acknowledge memory access with a bounded wait. Read data lands in
// the memory-data register (rdata) only when a load completes.
module mem_addr_unit
    import mem_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  NSRC        = 4,
    parameter int  TIMEOUT     = 16,
    parameter bit  ALIGN_CHECK = 1'b1,
    localparam int SEL_W       = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC*WIDTH-1:0] src_addr,
    input  logic [SEL_W-1:0]      addr_sel,
    input  logic                  start,
    input  logic                  write,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [WIDTH-1:0]      rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] addr_q,     addr_d;
    logic [WIDTH-1:0] wdata_q,    wdata_d;
    logic             we_q,       we_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] rdata_q,    rdata_d;
    logic             req_q,      req_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;

    logic [WIDTH-1:0] mux_addr;
    logic             sel_ok;
    logic             misaligned;

    addr_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_addr_src_mux (
        .src_addr (src_addr),
        .sel      (addr_sel),
        .addr_out (mux_addr)
    );

    // The select is re-validated from its latched copy, so a bad select is
    // caught even though the mux already forced the address to zero.
    assign sel_ok     = sel_in_range(16'(sel_q), NSRC);
    assign misaligned = ALIGN_CHECK && (addr_q[1:0] != 2'b00);

    // Next-state, datapath capture and registered-output decode for the FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        rdata_d    = rdata_q;
        req_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = mux_addr;
                    wdata_d    = wdata;
                    we_d       = write;
                    sel_d      = addr_sel;
                    err_code_d = ERR_NONE;
                    cnt_d      = '0;
                    state_d    = CHECK;
                end
            end

            CHECK: begin
                // Bad select outranks misalignment; neither path raises a request.
                if (!sel_ok) begin
                    err_code_d = ERR_SEL;
                    err_d      = 1'b1;
                    state_d    = ERR;
                end else if (misaligned) begin
                    err_code_d = ERR_ALIGN;
                    err_d      = 1'b1;
                    state_d    = ERR;
                end else begin
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                // An ack on the final allowed wait cycle still completes.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    err_d      = 1'b1;
                    state_d    = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    req_d = 1'b1;
                end
            end

            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears the request at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
            rdata_q    <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
